store_data_packer: RTL and testbench

- Write-side counterpart of the load-path extenders: narrows and aligns register store data (sb/sh/sw, optionally swl/swr) into a word-aligned 32-bit write with byte strobes.
- Sits between the MEM stage and the data-cache write port.
- Buffers accepted stores in a small FIFO and drives the cache port with a valid/ready handshake.
- Flags misaligned stores (AdES) instead of enqueuing them.

---
 rtl/store_data_packer.sv | 128 ++++++++++++
 tb/tb_store_data_packer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_data_packer.sv
// Store data packer: aligns sb/sh/sw (and swl/swr with UNALIGNED_STORE_EN) into word writes with byte strobes.
// One-cycle latency through a DEPTH-entry FIFO; req_ready drops when full, head held under wr_ready backpressure.
module store_data_packer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr,
  output logic        exc_illop,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        buf_empty
);

  logic [29:0]    addr_mem_q [DEPTH];
  logic [31:0]    data_mem_q [DEPTH];
  logic [3:0]     strb_mem_q [DEPTH];
  logic [PTR_W:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic           exc_ades_q, exc_illop_q;
  logic [31:0]    exc_badvaddr_q;

  logic [1:0]  off;
  logic [31:0] pk_data;
  logic [3:0]  pk_strb;
  logic        misal, illegal;
  logic        full, empty, accept, push, pop;

  assign off = req_addr[1:0];

  always_comb begin
    pk_data = '0;
    pk_strb = '0;
    misal   = 1'b0;
    illegal = 1'b0;
    case (req_op)
      3'b000: begin
        pk_data = {4{req_data[7:0]}};
        pk_strb = 4'b0001 << off;
      end
      3'b001: begin
        pk_data = {2{req_data[15:0]}};
        pk_strb = off[1] ? 4'b1100 : 4'b0011;
        misal   = off[0];
      end
      3'b010: begin
        pk_data = req_data;
        pk_strb = 4'b1111;
        misal   = (off != 2'd0);
      end
`ifdef UNALIGNED_STORE_EN
      // swl writes the upper bytes of rt into the low lanes up to off; swr the mirror image.
      3'b101: begin
        case (off)
          2'd0:    begin pk_data = req_data >> 24; pk_strb = 4'b0001; end
          2'd1:    begin pk_data = req_data >> 16; pk_strb = 4'b0011; end
          2'd2:    begin pk_data = req_data >> 8;  pk_strb = 4'b0111; end
          default: begin pk_data = req_data;       pk_strb = 4'b1111; end
        endcase
      end
      3'b110: begin
        case (off)
          2'd0:    begin pk_data = req_data;       pk_strb = 4'b1111; end
          2'd1:    begin pk_data = req_data << 8;  pk_strb = 4'b1110; end
          2'd2:    begin pk_data = req_data << 16; pk_strb = 4'b1100; end
          default: begin pk_data = req_data << 24; pk_strb = 4'b1000; end
        endcase
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && !misal && !illegal && (pk_strb != 4'b0000);
  assign pop       = wr_valid && wr_ready;
  assign wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d    = pop  ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      exc_ades_q     <= 1'b0;
      exc_illop_q    <= 1'b0;
      exc_badvaddr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
        strb_mem_q[i] <= '0;
      end
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      exc_ades_q     <= accept && misal;
      exc_illop_q    <= accept && illegal && !misal;
      exc_badvaddr_q <= (accept && misal) ? req_addr : 32'd0;
      if (push) begin
        addr_mem_q[wptr_q[PTR_W-1:0]] <= req_addr[31:2];
        data_mem_q[wptr_q[PTR_W-1:0]] <= pk_data;
        strb_mem_q[wptr_q[PTR_W-1:0]] <= pk_strb;
      end
    end
  end

  assign wr_valid     = !empty;
  assign buf_empty    = empty;
  assign wr_addr      = empty ? 32'd0 : {addr_mem_q[rptr_q[PTR_W-1:0]], 2'b00};
  assign wr_data      = empty ? 32'd0 : data_mem_q[rptr_q[PTR_W-1:0]];
  assign wr_strb      = empty ? 4'd0  : strb_mem_q[rptr_q[PTR_W-1:0]];
  assign exc_ades     = exc_ades_q;
  assign exc_illop    = exc_illop_q;
  assign exc_badvaddr = exc_badvaddr_q;

endmodule

// File: tb/tb_store_data_packer.sv
// Scoreboard bench for store_data_packer: directed stores, expected writes queued, monitor compares cache-port writes.
module tb_store_data_packer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;
  logic        exc_illop;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        buf_empty;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  store_data_packer #(.DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr), .exc_illop(exc_illop),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every cache-port handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn && wr_valid && wr_ready) begin
      wr_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=0x%08h data=0x%08h strb=%b, expected none",
                 wr_addr, wr_data, wr_strb);
      end else begin
        e = sb_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || wr_strb !== e.strb) begin
          errors++;
          $display("FAIL write: got addr=0x%08h data=0x%08h strb=%b expected addr=0x%08h data=0x%08h strb=%b",
                   wr_addr, wr_data, wr_strb, e.addr, e.data, e.strb);
        end
      end
    end
  end

  // Issues one request; returns 1 time unit after the accepting edge with req_valid dropped.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                      input bit exp_push, input wr_t exp);
    bit done = 1'b0;
    req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        if (exp_push) sb_q.push_back(exp);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got req_ready=0 for 20 cycles expected acceptance");
    end
  endtask

  function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = a; w.data = d; w.strb = s;
    return w;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_exc", {30'd0, exc_ades, exc_illop}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    // sb at offset 3
    send(3'b000, 32'h1000_0003, 32'h1234_56AB, 1'b1, mk(32'h1000_0000, 32'hABAB_ABAB, 4'b1000));
    chk("sb_latency_valid", {31'd0, wr_valid}, 32'd1);
    chk("sb_buf_empty0", {31'd0, buf_empty}, 32'd0);
    chk("sb_wr_strb", {28'd0, wr_strb}, 32'h8);
    @(posedge clk); #1;
    chk("sb_buf_empty1", {31'd0, buf_empty}, 32'd1);

    // sh aligned, then misaligned
    send(3'b001, 32'h0000_2002, 32'hCAFE_BEEF, 1'b1, mk(32'h0000_2000, 32'hBEEF_BEEF, 4'b1100));
    @(posedge clk); #1;
    send(3'b001, 32'h0000_2001, 32'hCAFE_BEEF, 1'b0, mk(0, 0, 0));
    chk("ades_pulse", {31'd0, exc_ades}, 32'd1);
    chk("ades_badvaddr", exc_badvaddr, 32'h0000_2001);
    chk("ades_no_push", {31'd0, buf_empty}, 32'd1);
    @(posedge clk); #1;
    chk("ades_one_cycle", {31'd0, exc_ades}, 32'd0);

    // sw misaligned
    send(3'b010, 32'h0000_0016, 32'h5555_5555, 1'b0, mk(0, 0, 0));
    chk("sw_ades", {31'd0, exc_ades}, 32'd1);
    chk("sw_badvaddr", exc_badvaddr, 32'h0000_0016);

    // Backpressure fills the FIFO
    wr_ready = 1'b0;
    send(3'b010, 32'h0000_0010, 32'h1111_1111, 1'b1, mk(32'h10, 32'h1111_1111, 4'hF));
    send(3'b010, 32'h0000_0014, 32'h2222_2222, 1'b1, mk(32'h14, 32'h2222_2222, 4'hF));
    chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
    chk("bp_head_data", wr_data, 32'h1111_1111);
    req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h18; req_data = 32'h3333_3333;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    chk("bp_head_stable", wr_data, 32'h1111_1111);
    chk("bp_head_addr", wr_addr, 32'h0000_0010);
    chk("bp_still_full", {31'd0, req_ready}, 32'd0);
    wr_ready = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_drained", sb_q.size(), 32'd0);
    chk("bp_req_ready_back", {31'd0, req_ready}, 32'd1);

    // Streaming: one write per cycle across several pointer wraps
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, d;
      a = 32'h100 + 32'(i * 4);
      d = 32'hA000_0000 + 32'(i);
      send(3'b010, a, d, 1'b1, mk(a, d, 4'hF));
      chk("stream_in_flight", {31'd0, wr_valid}, 32'd1);
    end
    @(posedge clk); #1;
    chk("stream_all_out", sb_q.size(), 32'd0);
    chk("stream_empty", {31'd0, buf_empty}, 32'd1);

    // Reset with two buffered entries
    wr_ready = 1'b0;
    send(3'b010, 32'h40, 32'hDEAD_0001, 1'b0, mk(0, 0, 0));
    send(3'b010, 32'h44, 32'hDEAD_0002, 1'b0, mk(0, 0, 0));
    chk("mid_full", {31'd0, req_ready}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("mid_rst_empty", {31'd0, buf_empty}, 32'd1);
    wr_ready = 1'b1;
    @(posedge clk); #1 resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_write", {31'd0, wr_valid}, 32'd0);

    // swl
`ifdef UNALIGNED_STORE_EN
    send(3'b101, 32'h0000_3001, 32'hAABB_CCDD, 1'b1, mk(32'h3000, 32'h0000_AABB, 4'b0011));
    chk("swl_illop", {31'd0, exc_illop}, 32'd0);
    chk("swl_strb", {28'd0, wr_strb}, 32'h3);
`else
    send(3'b101, 32'h0000_3001, 32'hAABB_CCDD, 1'b0, mk(0, 0, 0));
    chk("swl_illop", {31'd0, exc_illop}, 32'd1);
    chk("swl_no_push", {31'd0, buf_empty}, 32'd1);
`endif
    @(posedge clk); #1;
    chk("illop_one_cycle", {31'd0, exc_illop}, 32'd0);
    send(3'b011, 32'h0000_0020, 32'h0, 1'b0, mk(0, 0, 0));
    chk("op011_illop", {31'd0, exc_illop}, 32'd1);
    chk("op011_no_ades", {31'd0, exc_ades}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
